sdram_axi_arb: RTL and testbench

SDRAM_AXI_ARB -- requirements
Module: sdram_axi_arb

---
 rtl/sdram_axi_arb.sv | 197 +++++++++++++++++++
 tb/tb_sdram_axi_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_axi_arb.sv
// Two-requester arbiter in front of a single-beat AXI4 master port.
// One transaction is outstanding at a time; ties alternate round-robin.
// A busy-cycle watchdog forces an error completion if the slave stalls.
module sdram_axi_arb #(
   parameter int unsigned ADDR_W  = 31,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                AXI_CLK,
   input  logic                AXI_RSTN,
   input  logic [1:0]          rq_req,
   input  logic [1:0]          rq_we,
   input  logic [2*ADDR_W-1:0] rq_addr,
   input  logic [63:0]         rq_wdata,
   input  logic [7:0]          rq_wstrb,
   output logic [1:0]          rq_ack,
   output logic [31:0]         rq_rdata,
   output logic                rq_err,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [3:0]          m_awid,
   output logic [7:0]          m_awlen,
   output logic [1:0]          m_awburst,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [31:0]         m_wdata,
   output logic [3:0]          m_wstrb,
   output logic                m_wlast,
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [1:0]          m_bresp,
   input  logic [3:0]          m_bid,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [3:0]          m_arid,
   output logic [7:0]          m_arlen,
   output logic [1:0]          m_arburst,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [31:0]         m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic [3:0]          m_rid,
   input  logic                m_rlast
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR, BRESP, RD_AR, RDATA, DONE} state_t;

   state_t              state_q, state_d;
   logic                grant_q, last_grant_q, we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q, rdata_q;
   logic [3:0]          wstrb_q;
   logic                aw_done_q, w_done_q, err_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                grant_sel, do_grant, busy, tmo;
   logic                aw_fire, w_fire;
   logic [ADDR_W-1:0]   sel_addr;

   // Arbitration and handshake decode shared by next-state and data paths
   always_comb begin
      grant_sel = (&rq_req) ? ~last_grant_q : rq_req[1];
      do_grant  = (state_q == IDLE) && (|rq_req);
      sel_addr  = grant_sel ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
      busy      = (state_q == WR) || (state_q == BRESP) ||
                  (state_q == RD_AR) || (state_q == RDATA);
      tmo       = busy && (cnt_q == TMO_LAST);
      aw_fire   = (state_q == WR) && !aw_done_q && m_awready;
      w_fire    = (state_q == WR) && !w_done_q && m_wready;
   end

   // State register
   always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
      if (!AXI_RSTN) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic; the watchdog overrides any other transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|rq_req) state_d = rq_we[grant_sel] ? WR : RD_AR;
         WR:      if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = BRESP;
         BRESP:   if (m_bvalid) state_d = DONE;
         RD_AR:   if (m_arready) state_d = RDATA;
         RDATA:   if (m_rvalid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo) state_d = DONE;
   end

   // Grant capture, per-channel completion flags, watchdog and response capture
   always_ff @(posedge AXI_CLK or negedge AXI_RSTN) begin
      if (!AXI_RSTN) begin
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         if (do_grant) begin
            grant_q      <= grant_sel;
            last_grant_q <= grant_sel;
            we_q         <= rq_we[grant_sel];
            addr_q       <= {sel_addr[ADDR_W-1:2], 2'b00};
            wdata_q      <= grant_sel ? rq_wdata[63:32] : rq_wdata[31:0];
            wstrb_q      <= grant_sel ? rq_wstrb[7:4] : rq_wstrb[3:0];
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
         end else begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
         end
         cnt_q <= (busy && !tmo) ? cnt_q + 1'b1 : '0;
         if (tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end else if ((state_q == BRESP) && m_bvalid) begin
            err_q   <= m_bresp[1] || (m_bid != {3'b000, grant_q});
            rdata_q <= '0;
         end else if ((state_q == RDATA) && m_rvalid) begin
            err_q   <= m_rresp[1] || (m_rid != {3'b000, grant_q}) || !m_rlast;
            rdata_q <= m_rdata;
         end
      end
   end

   // Outputs decoded from state; forced to zero while reset is held
   always_comb begin
      rq_ack    = '0;
      rq_rdata  = '0;
      rq_err    = 1'b0;
      m_awvalid = 1'b0;
      m_awaddr  = '0;
      m_awid    = '0;
      m_awlen   = '0;
      m_awburst = '0;
      m_wvalid  = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = 1'b0;
      m_bready  = 1'b0;
      m_arvalid = 1'b0;
      m_araddr  = '0;
      m_arid    = '0;
      m_arlen   = '0;
      m_arburst = '0;
      m_rready  = 1'b0;
      if (AXI_RSTN) begin
         case (state_q)
            IDLE: begin
               m_bready = 1'b1;
               m_rready = 1'b1;
            end
            WR: begin
               if (!aw_done_q) begin
                  m_awvalid = 1'b1;
                  m_awaddr  = addr_q;
                  m_awid    = {3'b000, grant_q};
                  m_awburst = 2'b01;
               end
               if (!w_done_q) begin
                  m_wvalid = 1'b1;
                  m_wdata  = wdata_q;
                  m_wstrb  = wstrb_q;
                  m_wlast  = 1'b1;
               end
            end
            BRESP: m_bready = 1'b1;
            RD_AR: begin
               m_arvalid = 1'b1;
               m_araddr  = addr_q;
               m_arid    = {3'b000, grant_q};
               m_arburst = 2'b01;
            end
            RDATA: m_rready = 1'b1;
            DONE: begin
               rq_ack[grant_q] = 1'b1;
               rq_rdata        = we_q ? 32'h0 : rdata_q;
               rq_err          = err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_axi_arb.sv
// Directed bench for sdram_axi_arb: expectations are queued by the stimulus
// process; a single negedge process models the AXI slave and checks them.
module tb_sdram_axi_arb;

   localparam int unsigned AW = 31;

   logic          AXI_CLK = 1'b0;
   logic          AXI_RSTN;
   logic [1:0]    rq_req, rq_we;
   logic [2*AW-1:0] rq_addr;
   logic [63:0]   rq_wdata;
   logic [7:0]    rq_wstrb;
   logic [1:0]    rq_ack;
   logic [31:0]   rq_rdata;
   logic          rq_err;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [3:0]    m_awid, m_arid, m_bid, m_rid, m_wstrb;
   logic [7:0]    m_awlen, m_arlen;
   logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
   logic [31:0]   m_wdata, m_rdata;
   logic          m_bvalid, m_bready, m_arvalid, m_arready;
   logic          m_rvalid, m_rready, m_rlast;

   sdram_axi_arb #(.ADDR_W(AW), .TIMEOUT(16)) dut (
      .AXI_CLK(AXI_CLK), .AXI_RSTN(AXI_RSTN),
      .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr),
      .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
      .rq_ack(rq_ack), .rq_rdata(rq_rdata), .rq_err(rq_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awid(m_awid), .m_awlen(m_awlen), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arid(m_arid), .m_arlen(m_arlen), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast)
   );

   always #5 AXI_CLK = ~AXI_CLK;

   typedef struct {logic [AW-1:0] addr; logic [3:0] id; int unsigned wt;} ax_t;
   typedef struct {logic [31:0] data; logic [3:0] strb;} w_t;
   typedef struct {int unsigned idx; logic [31:0] rdata; logic err;} ack_t;

   ax_t  aw_q[$], ar_q[$];
   w_t   w_q[$];
   ack_t ack_q[$];

   int unsigned checks = 0, errors = 0;

   // slave configuration, written by stimulus
   logic        silent = 1'b0, hold_r = 1'b0;
   int unsigned aw_delay = 0;
   logic [1:0]  rresp_cfg = 2'b00;
   logic [31:0] rtab [2];
   int unsigned inject_req = 0, inject_done = 0;
   logic        finish_req = 1'b0, finish_ack = 1'b0;

   // slave state
   logic        aw_got, w_got, b_pend, r_pend;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [3:0]  b_id, r_id;
   int unsigned aw_run;
   logic [AW-1:0] aw_prev;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // slave model + scoreboard monitor
   initial begin
      ax_t e; w_t ew; ack_t ea;
      {aw_got, w_got, b_pend, r_pend, aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
      b_id = '0; r_id = '0; aw_run = 0; aw_prev = '0;
      {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
      m_bresp = '0; m_bid = '0; m_rdata = '0; m_rresp = '0; m_rid = '0;
      forever begin
         @(negedge AXI_CLK);
         if (!AXI_RSTN) begin
            chk("reset_outputs_zero", 64'(|{rq_ack, rq_rdata, rq_err, m_awvalid, m_awaddr,
                m_awid, m_awlen, m_awburst, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
                m_arvalid, m_araddr, m_arid, m_arlen, m_arburst, m_rready}), 64'd0);
            {aw_got, w_got, b_pend, r_pend, aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
            aw_run = 0;
            {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast} = '0;
         end else begin
            if (aw_hs) aw_got = 1'b1;
            if (w_hs)  w_got  = 1'b1;
            if (b_hs)  b_pend = 1'b0;
            if (ar_hs) r_pend = 1'b1;
            if (r_hs)  r_pend = 1'b0;
            if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
            if (inject_req != inject_done) begin
               inject_done++;
               b_pend = 1'b1;
               b_id   = 4'd1;
               chk("stale_bready_in_idle", 64'(m_bready), 64'd1);
            end
            if (rq_ack != 2'b00) begin
               if (ack_q.size() == 0) chk("unexpected_ack", 64'(rq_ack), 64'd0);
               else begin
                  ea = ack_q.pop_front();
                  chk("ack_onehot", 64'(rq_ack), 64'(2'b01 << ea.idx));
                  chk("ack_rdata", 64'(rq_rdata), 64'(ea.rdata));
                  chk("ack_err", 64'(rq_err), 64'(ea.err));
               end
            end
            if (m_awvalid) begin
               if (aw_run > 0) chk("awaddr_stable", 64'(m_awaddr), 64'(aw_prev));
               aw_run++;
               aw_prev = m_awaddr;
            end else begin
               if (silent && aw_run > 0) chk("timeout_busy_cycles", 64'(aw_run), 64'd16);
               aw_run = 0;
            end
            m_awready = !silent && m_awvalid && (aw_run > aw_delay);
            m_wready  = !silent;
            m_arready = !silent;
            m_bvalid  = b_pend; m_bid = b_id; m_bresp = 2'b00;
            m_rvalid  = r_pend && !hold_r;
            m_rdata   = rtab[r_id[0]]; m_rresp = rresp_cfg; m_rid = r_id; m_rlast = 1'b1;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            if (aw_hs) begin
               b_id = m_awid;
               if (aw_q.size() == 0) chk("unexpected_aw", 64'(m_awvalid), 64'd0);
               else begin
                  e = aw_q.pop_front();
                  chk("awaddr", 64'(m_awaddr), 64'(e.addr));
                  chk("awid", 64'(m_awid), 64'(e.id));
                  chk("awlen_burst", 64'({m_awlen, m_awburst}), 64'({8'd0, 2'b01}));
                  chk("aw_wait_cycles", 64'(aw_run - 1), 64'(e.wt));
               end
            end
            if (w_hs) begin
               if (w_q.size() == 0) chk("unexpected_w_beat", 64'(m_wvalid), 64'd0);
               else begin
                  ew = w_q.pop_front();
                  chk("wdata", 64'(m_wdata), 64'(ew.data));
                  chk("wstrb_wlast", 64'({m_wstrb, m_wlast}), 64'({ew.strb, 1'b1}));
               end
            end
            if (ar_hs) begin
               r_id = m_arid;
               if (ar_q.size() == 0) chk("unexpected_ar", 64'(m_arvalid), 64'd0);
               else begin
                  e = ar_q.pop_front();
                  chk("araddr", 64'(m_araddr), 64'(e.addr));
                  chk("arid", 64'(m_arid), 64'(e.id));
                  chk("arlen_burst", 64'({m_arlen, m_arburst}), 64'({8'd0, 2'b01}));
               end
            end
            if (finish_req && !finish_ack) begin
               chk("pending_expectations", 64'(ack_q.size() + aw_q.size() + w_q.size()
                   + ar_q.size()), 64'd0);
               finish_ack = 1'b1;
            end
         end
      end
   end

   task automatic issue(input int unsigned i, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      rq_we[i] = we;
      if (i == 0) begin
         rq_addr[AW-1:0] = a; rq_wdata[31:0] = d; rq_wstrb[3:0] = s;
      end else begin
         rq_addr[2*AW-1:AW] = a; rq_wdata[63:32] = d; rq_wstrb[7:4] = s;
      end
      rq_req[i] = 1'b1;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned n = 0;
      while (rq_req != 2'b00) begin
         @(negedge AXI_CLK);
         for (int i = 0; i < 2; i++) if (rq_ack[i]) rq_req[i] = 1'b0;
         n++;
         if (n > budget && rq_req != 2'b00) begin
            $display("FAIL wait_done: req still 0b%b after %0d cycles, required 0b00", rq_req, budget);
            $fatal(1, "acknowledge not received");
         end
      end
      @(negedge AXI_CLK);
   endtask

   initial begin
      AXI_RSTN = 1'b0;
      rq_req = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
      rtab[0] = '0; rtab[1] = '0;
      repeat (3) @(negedge AXI_CLK);
      #2 AXI_RSTN = 1'b1;
      @(negedge AXI_CLK);

      // both read from reset: requester 0 first, low address bits cleared
      rtab[0] = 32'h1111_1111; rtab[1] = 32'h2222_2222;
      ar_q.push_back('{31'h200, 4'd0, 0}); ar_q.push_back('{31'h300, 4'd1, 0});
      ack_q.push_back('{0, 32'h1111_1111, 1'b0}); ack_q.push_back('{1, 32'h2222_2222, 1'b0});
      issue(0, 1'b0, 31'h200, '0, '0); issue(1, 1'b0, 31'h303, '0, '0);
      wait_done(30);

      // single write, slave always ready
      aw_q.push_back('{31'h100, 4'd0, 0}); w_q.push_back('{32'hDEAD_BEEF, 4'hF});
      ack_q.push_back('{0, 32'h0, 1'b0});
      issue(0, 1'b1, 31'h100, 32'hDEAD_BEEF, 4'hF);
      wait_done(20);

      // awready held off 3 cycles, wready immediate
      aw_delay = 3;
      aw_q.push_back('{31'h44, 4'd1, 3}); w_q.push_back('{32'h1234_5678, 4'h5});
      ack_q.push_back('{1, 32'h0, 1'b0});
      issue(1, 1'b1, 31'h47, 32'h1234_5678, 4'h5);
      wait_done(20);
      aw_delay = 0;

      // read with SLVERR
      rresp_cfg = 2'b10; rtab[0] = 32'hCAFE_F00D;
      ar_q.push_back('{31'h80, 4'd0, 0}); ack_q.push_back('{0, 32'hCAFE_F00D, 1'b1});
      issue(0, 1'b0, 31'h80, '0, '0);
      wait_done(20);
      rresp_cfg = 2'b00;

      // silent slave: watchdog completion, then a stale B is absorbed in IDLE
      silent = 1'b1;
      ack_q.push_back('{1, 32'h0, 1'b1});
      issue(1, 1'b1, 31'h10, 32'h5555_AAAA, 4'hF);
      wait_done(40);
      silent = 1'b0;
      inject_req++;
      repeat (6) @(negedge AXI_CLK);

      // reset while waiting for read data; no ack may appear
      hold_r = 1'b1;
      ar_q.push_back('{31'h40, 4'd0, 0});
      issue(0, 1'b0, 31'h40, '0, '0);
      for (int n = 0; n <= 20 && !r_pend; n++) begin
         @(negedge AXI_CLK);
         if (n == 20 && !r_pend) begin
            $display("FAIL ar_handshake_wait: r_pend 0 after 20 cycles, required 1");
            $fatal(1, "read address never accepted");
         end
      end
      repeat (2) @(negedge AXI_CLK);
      @(posedge AXI_CLK);
      #1 AXI_RSTN = 1'b0; rq_req = '0; hold_r = 1'b0;
      repeat (2) @(negedge AXI_CLK);
      #2 AXI_RSTN = 1'b1;
      @(negedge AXI_CLK);

      // after reset requester 0 wins the tie again
      rtab[0] = 32'hA5A5_A5A5; rtab[1] = 32'h5A5A_5A5A;
      ar_q.push_back('{31'h500, 4'd0, 0}); ar_q.push_back('{31'h600, 4'd1, 0});
      ack_q.push_back('{0, 32'hA5A5_A5A5, 1'b0}); ack_q.push_back('{1, 32'h5A5A_5A5A, 1'b0});
      issue(0, 1'b0, 31'h500, '0, '0); issue(1, 1'b0, 31'h600, '0, '0);
      wait_done(30);

      finish_req = 1'b1;
      for (int n = 0; n < 5 && !finish_ack; n++) @(negedge AXI_CLK);
      if (!finish_ack) begin
         $display("FAIL finish_handshake: monitor idle flag 0, required 1");
         $fatal(1, "monitor did not respond");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
